tqvp_uart_tx_fifo: RTL and testbench

- Byte-register peripheral that sits directly downstream of the SPI register bridge in the TinyQV peripheral test harness, in the slot the harness reserves for the peripheral under test.
- Accepts bytes written over the 4-bit address / 8-bit data register bus and buffers them in a small FIFO.
- Serialises them as 8N1 UART frames on uo_out[0] at a programmable baud divider.
- Provides status readback and flow control via a CTS input.

---
 rtl/tqvp_uart_tx_fifo.sv | 137 +++++++++++++
 tb/tb_tqvp_uart_tx_fifo.sv | 338 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tqvp_uart_tx_fifo.sv
// tqvp_uart_tx_fifo: register-mapped byte FIFO feeding an 8N1 UART transmitter with CTS flow control.
// Define TQVP_UART_PARITY_EN to add a parity bit selected through CTRL[4:3].
module tqvp_uart_tx_fifo #(
    parameter int          DEPTH     = 4,
    parameter logic [15:0] DIV_RESET = 16'd103
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] ui_in,
    output logic [7:0] uo_out,
    input  logic [3:0] address,
    input  logic       data_write,
    input  logic [7:0] data_in,
    output logic [7:0] data_out
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
    state_t state, state_d;
    logic [7:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0] level;
    logic [15:0] div, baud_cnt;
    logic [7:0] shift, shift_d, ctrl_rd;
    logic [2:0] bit_cnt;
    logic tx, tx_d, busy, overflow, enable, with_par, par_bit;
    logic full, empty, tick, last_bit, pop_ok, pop, push_req, push, ctrl_wr, flush;
    logic unused;

    assign unused = &{1'b0, ui_in[7:1]};
    // level never exceeds DEPTH, a power of two, so its top bit alone means full
    assign full = level[AW];
    assign empty = level == '0;
    assign ctrl_wr = data_write && address == 4'h4;
    assign flush = ctrl_wr && data_in[2];
    assign push_req = data_write && address == 4'h0;
    assign tick = baud_cnt == 16'd0;
    assign last_bit = bit_cnt == 3'd7;
    assign pop_ok = enable && !ui_in[0] && !empty && !flush;
    assign pop = pop_ok && (state == IDLE || (state == STOP && tick));
    assign push = push_req && (!full || pop);

`ifdef TQVP_UART_PARITY_EN
    logic parity_en, odd, par;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            parity_en <= 1'b0;
            odd <= 1'b0;
            par <= 1'b0;
        end else begin
            if (ctrl_wr) begin
                parity_en <= data_in[3];
                odd <= data_in[4];
            end
            if (pop) par <= ^mem[rd_ptr];
        end
    end
    assign with_par = parity_en;
    assign par_bit = par ^ odd;
    assign ctrl_rd = {3'b000, odd, parity_en, 2'b00, enable};
`else
    assign with_par = 1'b0;
    assign par_bit = 1'b1;
    assign ctrl_rd = {7'b0, enable};
`endif

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= data_in;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level <= '0;
            overflow <= 1'b0;
            div <= DIV_RESET;
            enable <= 1'b1;
        end else begin
            if (flush) begin
                rd_ptr <= wr_ptr;
                level <= '0;
            end else begin
                if (pop) rd_ptr <= rd_ptr + AW'(1);
                level <= level + LW'(push) - LW'(pop);
            end
            if (push) wr_ptr <= wr_ptr + AW'(1);
            overflow <= (overflow && !(ctrl_wr && data_in[1])) || (push_req && full && !pop);
            if (data_write && address == 4'h2) div[7:0] <= data_in;
            if (data_write && address == 4'h3) div[15:8] <= data_in;
            if (ctrl_wr) enable <= data_in[0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            tx <= 1'b1;
            busy <= 1'b0;
            shift <= '0;
            baud_cnt <= '0;
            bit_cnt <= '0;
        end else begin
            state <= state_d;
            tx <= tx_d;
            busy <= state_d != IDLE;
            shift <= shift_d;
            // reloading from div at each boundary lets a new divisor apply without truncating a bit
            baud_cnt <= (pop || (state != IDLE && tick)) ? div :
                        state != IDLE ? baud_cnt - 16'd1 : baud_cnt;
            bit_cnt <= state != DATA ? 3'd0 : tick ? bit_cnt + 3'd1 : bit_cnt;
        end
    end

    always_comb begin
        state_d = state;
        case (state)
            IDLE:    if (pop) state_d = START;
            START:   if (tick) state_d = DATA;
            DATA:    if (tick && last_bit) state_d = with_par ? PARITY : STOP;
            PARITY:  if (tick) state_d = STOP;
            STOP:    if (tick) state_d = pop ? START : IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        shift_d = pop ? mem[rd_ptr] : (state == DATA && tick && !last_bit) ? {1'b0, shift[7:1]} : shift;
        tx_d = state_d == START ? 1'b0 : state_d == DATA ? shift_d[0] : state_d == PARITY ? par_bit : 1'b1;
    end

    assign uo_out = {4'b0000, overflow, !full, busy, tx};
    assign data_out = address == 4'h1 ? {busy, full, empty, overflow, 4'(level)} :
                      address == 4'h2 ? div[7:0] :
                      address == 4'h3 ? div[15:8] :
                      address == 4'h4 ? ctrl_rd : 8'h00;
endmodule

// File: tb/tb_tqvp_uart_tx_fifo.sv
// tb_tqvp_uart_tx_fifo: scoreboard bench; bytes are queued on TXDATA writes and checked as frames leave tx.
module tb_tqvp_uart_tx_fifo;
    logic clk = 1'b0, rst_n = 1'b0, data_write = 1'b0;
    logic [7:0] ui_in = 8'h00, data_in = 8'h00;
    logic [3:0] address = 4'h0;
    logic [7:0] uo_out, data_out;
    logic tx, busy;
    int tests = 0, failed = 0, cyc = 0;
    logic [7:0] sb[$];

    tqvp_uart_tx_fifo dut (
        .clk(clk), .rst_n(rst_n), .ui_in(ui_in), .uo_out(uo_out),
        .address(address), .data_write(data_write), .data_in(data_in), .data_out(data_out)
    );

    assign tx = uo_out[0];
    assign busy = uo_out[1];
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
        $fatal(1);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [3:0] a, input logic [7:0] d);
        address = a;
        data_in = d;
        data_write = 1'b1;
        step();
        data_write = 1'b0;
    endtask

    task automatic rd(input logic [3:0] a, output logic [7:0] d);
        address = a;
        #1;
        d = data_out;
    endtask

    // Scoreboard consumer: waits for a start bit, samples mid-bit, pops and compares.
    task automatic rx_frame(input int div, output int t_start);
        logic [7:0] got, exp;
        int n;
        n = 0;
        while (tx !== 1'b0 && n < 5000) begin
            step();
            n++;
        end
        t_start = cyc;
        tests++;
        if (tx !== 1'b0) begin
            failed++;
            $display("FAIL rx_start: tx=%b after %0d cycles, required a start bit", tx, n);
            return;
        end
        repeat (div / 2) step();
        for (int i = 0; i < 8; i++) begin
            repeat (div + 1) step();
            got[i] = tx;
        end
        repeat (div + 1) step();
        exp = sb.size() != 0 ? sb.pop_front() : 8'hxx;
        tests++;
        if (got !== exp || tx !== 1'b1) begin
            failed++;
            $display("FAIL rx_frame: got %h stop %b, required %h stop 1", got, tx, exp);
        end
    endtask

    task automatic test_reset();
        logic [3:0] addrs [6] = '{4'h1, 4'h2, 4'h3, 4'h4, 4'h0, 4'h9};
        logic [7:0] exps [6] = '{8'h20, 8'h67, 8'h00, 8'h01, 8'h00, 8'h00};
        logic [7:0] v;
        rst_n = 1'b0;
        repeat (3) step();
        rst_n = 1'b1;
        step();
        tests++;
        if (uo_out !== 8'h05) begin
            failed++;
            $display("FAIL reset_uo_out: got %h, required 05", uo_out);
        end
        for (int i = 0; i < 6; i++) begin
            rd(addrs[i], v);
            tests++;
            if (v !== exps[i]) begin
                failed++;
                $display("FAIL reset_reg%0h: got %h, required %h", addrs[i], v, exps[i]);
            end
        end
    endtask

    task automatic test_frame();
        logic [7:0] b, got;
        logic exp_tx;
        int bad_tx = 0, bad_busy = 0;
        wr(4'h2, 8'h03);
        wr(4'h3, 8'h00);
        wr(4'h0, 8'hA5);
        sb.push_back(8'hA5);
        tests++;
        if (tx !== 1'b1 || busy !== 1'b0) begin
            failed++;
            $display("FAIL frame_latency: tx %b busy %b, required tx 1 busy 0 before the pop edge", tx, busy);
        end
        b = sb.pop_front();
        step();
        for (int c = 0; c < 40; c++) begin
            exp_tx = c < 4 ? 1'b0 : c >= 36 ? 1'b1 : b[c / 4 - 1];
            if (tx !== exp_tx) bad_tx++;
            if (busy !== 1'b1) bad_busy++;
            if (c % 4 == 2 && c >= 4 && c < 36) got[c / 4 - 1] = tx;
            step();
        end
        tests++;
        if (bad_tx != 0 || got !== b) begin
            failed++;
            $display("FAIL frame_wave: %0d bad tx cycles, decoded %h, required 0 bad and %h", bad_tx, got, b);
        end
        tests++;
        if (bad_busy != 0 || busy !== 1'b0 || tx !== 1'b1) begin
            failed++;
            $display("FAIL frame_busy: %0d low cycles, end busy %b tx %b, required 40 busy clocks then 0/1", bad_busy, busy, tx);
        end
    endtask

    task automatic test_overflow_back_to_back();
        logic [7:0] v;
        int t [4];
        wr(4'h2, 8'h00);
        wr(4'h4, 8'h00);
        for (int i = 0; i < 5; i++) begin
            wr(4'h0, 8'h11 + 8'(i));
            if (i < 4) sb.push_back(8'h11 + 8'(i));
        end
        rd(4'h1, v);
        tests++;
        if (v !== 8'h54 || uo_out !== 8'h09) begin
            failed++;
            $display("FAIL overflow_status: status %h uo_out %h, required 54 and 09", v, uo_out);
        end
        wr(4'h4, 8'h03);
        rd(4'h1, v);
        tests++;
        if (v !== 8'h44) begin
            failed++;
            $display("FAIL overflow_clear: status %h, required 44", v);
        end
        for (int i = 0; i < 4; i++) rx_frame(0, t[i]);
        for (int i = 1; i < 4; i++) begin
            tests++;
            if (t[i] - t[i - 1] != 10) begin
                failed++;
                $display("FAIL b2b_gap%0d: start spacing %0d, required 10", i, t[i] - t[i - 1]);
            end
        end
        repeat (2) step();
        rd(4'h1, v);
        tests++;
        if (v !== 8'h20) begin
            failed++;
            $display("FAIL b2b_idle: status %h, required 20", v);
        end
    endtask

    task automatic test_cts();
        logic [7:0] v;
        int t;
        wr(4'h2, 8'h01);
        ui_in = 8'h01;
        wr(4'h0, 8'h5A);
        sb.push_back(8'h5A);
        wr(4'h0, 8'hC3);
        sb.push_back(8'hC3);
        repeat (20) step();
        rd(4'h1, v);
        tests++;
        if (tx !== 1'b1 || busy !== 1'b0 || v !== 8'h02) begin
            failed++;
            $display("FAIL cts_hold: tx %b busy %b status %h, required 1 0 02", tx, busy, v);
        end
        ui_in = 8'h00;
        step();
        tests++;
        if (tx !== 1'b0 || busy !== 1'b1) begin
            failed++;
            $display("FAIL cts_release: tx %b busy %b, required 0 1", tx, busy);
        end
        fork
            rx_frame(1, t);
            begin
                repeat (3) step();
                ui_in = 8'h01;
            end
        join
        repeat (10) step();
        rd(4'h1, v);
        tests++;
        if (busy !== 1'b0 || v !== 8'h01) begin
            failed++;
            $display("FAIL cts_midframe: busy %b status %h, required 0 and 01", busy, v);
        end
        ui_in = 8'h00;
        rx_frame(1, t);
    endtask

    task automatic test_flush();
        logic [7:0] v;
        int t;
        wr(4'h2, 8'h03);
        wr(4'h0, 8'h3C);
        sb.push_back(8'h3C);
        wr(4'h0, 8'h99);
        wr(4'h0, 8'h66);
        fork
            rx_frame(3, t);
            begin
                repeat (8) step();
                wr(4'h4, 8'h05);
                rd(4'h1, v);
                tests++;
                if (v !== 8'hA0) begin
                    failed++;
                    $display("FAIL flush_level: status %h, required A0", v);
                end
            end
        join
        repeat (6) step();
        rd(4'h1, v);
        tests++;
        if (v !== 8'h20 || tx !== 1'b1) begin
            failed++;
            $display("FAIL flush_idle: status %h tx %b, required 20 and 1", v, tx);
        end
    endtask

    task automatic test_async_reset();
        logic [7:0] v;
        wr(4'h2, 8'h03);
        wr(4'h0, 8'h00);
        wr(4'h0, 8'h77);
        repeat (4) step();
        tests++;
        if (tx !== 1'b0 || busy !== 1'b1) begin
            failed++;
            $display("FAIL arst_pre: tx %b busy %b, required 0 1", tx, busy);
        end
        rst_n = 1'b0;
        #1;
        tests++;
        if (uo_out !== 8'h05) begin
            failed++;
            $display("FAIL arst_now: uo_out %h, required 05", uo_out);
        end
        step();
        rst_n = 1'b1;
        step();
        rd(4'h1, v);
        tests++;
        if (v !== 8'h20) begin
            failed++;
            $display("FAIL arst_fifo: status %h, required 20", v);
        end
        rd(4'h2, v);
        tests++;
        if (v !== 8'h67) begin
            failed++;
            $display("FAIL arst_div: div lo %h, required 67", v);
        end
    endtask

    task automatic test_ctrl_parity();
`ifdef TQVP_UART_PARITY_EN
        localparam logic [7:0] CTRL_EXP = 8'h19;
        localparam int LEN = 22;
`else
        localparam logic [7:0] CTRL_EXP = 8'h01;
        localparam int LEN = 20;
`endif
        logic [7:0] v, got, b;
        logic [99:0] wave;
        int n;
        wr(4'h4, 8'h19);
        rd(4'h4, v);
        tests++;
        if (v !== CTRL_EXP) begin
            failed++;
            $display("FAIL ctrl_readback: got %h, required %h", v, CTRL_EXP);
        end
        wr(4'h2, 8'h01);
        wr(4'h0, 8'h03);
        sb.push_back(8'h03);
        step();
        n = 0;
        while (busy === 1'b1 && n < 100) begin
            wave[n] = tx;
            n++;
            step();
        end
        for (int i = 0; i < 8; i++) got[i] = wave[2 + 2 * i];
        b = sb.pop_front();
        tests++;
        if (n != LEN || wave[0] !== 1'b0 || got !== b || wave[LEN - 2] !== 1'b1) begin
            failed++;
            $display("FAIL parity_frame: len %0d data %h stop %b, required len %0d data %h stop 1", n, got, wave[LEN - 2], LEN, b);
        end
`ifdef TQVP_UART_PARITY_EN
        tests++;
        if (wave[18] !== 1'b1) begin
            failed++;
            $display("FAIL parity_bit: got %b, required 1", wave[18]);
        end
`endif
    endtask

    initial begin
        test_reset();
        test_frame();
        test_overflow_back_to_back();
        test_cts();
        test_flush();
        test_async_reset();
        test_ctrl_parity();
        tests++;
        if (sb.size() != 0) begin
            failed++;
            $display("FAIL sb_drain: %0d bytes never seen on tx, required 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule
